// File: rtl/pic16f84_cycle_sequencer_if.sv
// Signal bundle between the PIC16F84 cycle sequencer and its neighbours: phase strobes,
// program ROM fetch, redirect requests from the execute unit and the pipeline outputs.
interface pic16f84_cycle_sequencer_if #(
  parameter int unsigned PC_WIDTH    = 13,
  parameter int unsigned INSTR_WIDTH = 14
);
  logic                   q1;
  logic                   q2;
  logic                   q3;
  logic                   q4;
  logic                   hold;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   branch_req;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   skip_req;
  logic                   irq_req;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   ir_valid;
  logic                   irq_ack;
  logic [PC_WIDTH-1:0]    ret_pc;
  logic                   phase_err;

  // The sequencer is the master: it consumes strobes/requests and drives the fetch side.
  modport master (
    input  q1, q2, q3, q4, hold, prog_data, branch_req, branch_target, skip_req, irq_req,
    output pc, ir, ir_valid, irq_ack, ret_pc, phase_err
  );

  modport slave (
    output q1, q2, q3, q4, hold, prog_data, branch_req, branch_target, skip_req, irq_req,
    input  pc, ir, ir_valid, irq_ack, ret_pc, phase_err
  );
endinterface

// File: rtl/pic16f84_cycle_sequencer.sv
// PIC16F84 instruction-cycle sequencer: two-stage fetch/execute pipeline driven by Q1..Q4
// strobes, owning the PC, fetch buffer and IR, with branch/interrupt/skip redirects on Q4.
module pic16f84_cycle_sequencer #(
  parameter int unsigned         PC_WIDTH    = 13,
  parameter int unsigned         INSTR_WIDTH = 14,
  parameter logic [PC_WIDTH-1:0] RESET_VEC   = 'h000,
  parameter logic [PC_WIDTH-1:0] IRQ_VEC     = 'h004
) (
  input  logic                          clk,
  input  logic                          rst,
  pic16f84_cycle_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    EV_NONE,
    EV_Q1,
    EV_Q4,
    EV_MULTI
  } phase_ev_e;

  phase_ev_e              w_ev;
  logic [3:0]             w_strobes;

  logic [PC_WIDTH-1:0]    r_pc,        w_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_ir,        w_ir_nxt;
  logic                   r_ir_valid,  w_ir_valid_nxt;
  logic [INSTR_WIDTH-1:0] r_fetch_buf, w_fetch_buf_nxt;
  logic                   r_fetch_valid, w_fetch_valid_nxt;
  logic                   r_irq_ack,   w_irq_ack_nxt;
  logic [PC_WIDTH-1:0]    r_ret_pc,    w_ret_pc_nxt;
  logic                   r_phase_err, w_phase_err_nxt;

  assign w_strobes = {bus.q1, bus.q2, bus.q3, bus.q4};

  // Q2/Q3 belong to the execute unit, so they decode to no sequencer action.
  always_comb begin
    w_ev = EV_NONE;
    if (!bus.hold) begin
      if ($countones(w_strobes) > 1) w_ev = EV_MULTI;
      else if (bus.q1)               w_ev = EV_Q1;
      else if (bus.q4)               w_ev = EV_Q4;
    end
  end

  // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_ir_nxt          = r_ir;
    w_ir_valid_nxt    = r_ir_valid;
    w_fetch_buf_nxt   = r_fetch_buf;
    w_fetch_valid_nxt = r_fetch_valid;
    w_irq_ack_nxt     = r_irq_ack;
    w_ret_pc_nxt      = r_ret_pc;
    w_phase_err_nxt   = r_phase_err;

    case (w_ev)
      EV_MULTI: w_phase_err_nxt = 1'b1;
      EV_Q1: begin
        w_ir_nxt       = r_fetch_buf;
        w_ir_valid_nxt = r_fetch_valid;
        w_irq_ack_nxt  = 1'b0;
      end
      EV_Q4: begin
        // Redirects only come from a live instruction; a flushed cycle always fetches.
        if (r_ir_valid && bus.branch_req) begin
          w_pc_nxt          = bus.branch_target;
          w_fetch_valid_nxt = 1'b0;
        end else if (r_ir_valid && bus.irq_req) begin
          w_ret_pc_nxt      = r_pc;
          w_pc_nxt          = IRQ_VEC;
          w_fetch_valid_nxt = 1'b0;
          w_irq_ack_nxt     = 1'b1;
        end else begin
          w_fetch_buf_nxt   = bus.prog_data;
          w_fetch_valid_nxt = !(r_ir_valid && bus.skip_req);
          w_pc_nxt          = r_pc + PC_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together
  // from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_VEC;
      r_ir          <= '0;
      r_ir_valid    <= 1'b0;
      r_fetch_buf   <= '0;
      r_fetch_valid <= 1'b0;
      r_irq_ack     <= 1'b0;
      r_ret_pc      <= '0;
      r_phase_err   <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_ir_valid    <= w_ir_valid_nxt;
      r_fetch_buf   <= w_fetch_buf_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_irq_ack     <= w_irq_ack_nxt;
      r_ret_pc      <= w_ret_pc_nxt;
      r_phase_err   <= w_phase_err_nxt;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.ir        = r_ir;
  assign bus.ir_valid  = r_ir_valid;
  assign bus.irq_ack   = r_irq_ack;
  assign bus.ret_pc    = r_ret_pc;
  assign bus.phase_err = r_phase_err;

endmodule

// File: tb/tb_pic16f84_cycle_sequencer.sv
// Self-checking bench for the cycle sequencer: directed pipeline scenarios, then randomized
// strobes/redirects compared every clock against an instruction-level reference model.
module tb_pic16f84_cycle_sequencer;

  localparam int          PW      = 13;
  localparam int          IW      = 14;
  localparam int unsigned SPAN    = 1 << PW;
  localparam int unsigned IRQ_PC  = 4;
  localparam logic [3:0]  S_Q1    = 4'b1000;
  localparam logic [3:0]  S_Q2    = 4'b0100;
  localparam logic [3:0]  S_Q3    = 4'b0010;
  localparam logic [3:0]  S_Q4    = 4'b0001;

  typedef struct {
    logic [IW-1:0] data;
    bit            live;
  } fetch_t;

  logic clk = 1'b0;
  logic rst;

  pic16f84_cycle_sequencer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

  pic16f84_cycle_sequencer #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .RESET_VEC  (13'h000),
    .IRQ_VEC    (13'h004)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [SPAN];

  // Reference model: the instruction in flight plus the architectural outputs.
  int unsigned   m_pc;
  fetch_t        m_fetch;
  logic [IW-1:0] m_ir;
  bit            m_irv;
  bit            m_ack;
  int unsigned   m_ret;
  bit            m_err;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, int unsigned obs, int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(bit r, logic [3:0] q, bit h, bit br, int unsigned tgt, bit sk,
                            bit irq);
    if (r) begin
      m_pc = 0; m_ir = '0; m_irv = 0; m_fetch = '{data: '0, live: 0};
      m_ack = 0; m_ret = 0; m_err = 0;
      return;
    end
    if (h || q == 4'b0000) return;
    if ($countones(q) > 1) begin
      m_err = 1;
      return;
    end
    if (q == S_Q1) begin
      m_ir  = m_fetch.data;
      m_irv = m_fetch.live;
      m_ack = 0;
    end else if (q == S_Q4) begin
      if (m_irv && br) begin
        m_pc = tgt % SPAN;
        m_fetch.live = 0;
      end else if (m_irv && irq) begin
        m_ret = m_pc;
        m_pc  = IRQ_PC;
        m_fetch.live = 0;
        m_ack = 1;
      end else begin
        m_fetch = '{data: rom[m_pc], live: !(m_irv && sk)};
        m_pc    = (m_pc + 1) % SPAN;
      end
    end
  endtask

  task automatic compare_all();
    check("pc",        bus.pc,        m_pc);
    check("ir",        bus.ir,        m_ir);
    check("ir_valid",  bus.ir_valid,  m_irv);
    check("irq_ack",   bus.irq_ack,   m_ack);
    check("ret_pc",    bus.ret_pc,    m_ret);
    check("phase_err", bus.phase_err, m_err);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare 1 ns later.
  task automatic step(bit r, logic [3:0] q, bit h, bit br, int unsigned tgt, bit sk, bit irq);
    rst = r;
    {bus.q1, bus.q2, bus.q3, bus.q4} = q;
    bus.hold          = h;
    bus.branch_req    = br;
    bus.branch_target = PW'(tgt);
    bus.skip_req      = sk;
    bus.irq_req       = irq;
    bus.prog_data     = rom[bus.pc];
    @(posedge clk);
    model_edge(r, q, h, br, tgt, sk, irq);
    #1;
    compare_all();
  endtask

  task automatic run_cycle(bit br, int unsigned tgt, bit sk, bit irq, bit hold_q4);
    step(0, S_Q1, 0, br, tgt, sk, irq);
    step(0, S_Q2, 0, br, tgt, sk, irq);
    step(0, S_Q3, 0, br, tgt, sk, irq);
    step(0, S_Q4, hold_q4, br, tgt, sk, irq);
  endtask

  initial begin
    for (int a = 0; a < int'(SPAN); a++) rom[a] = IW'($urandom);
    rst = 1'b1;
    {bus.q1, bus.q2, bus.q3, bus.q4} = 4'b0000;
    bus.hold = 0; bus.branch_req = 0; bus.branch_target = '0;
    bus.skip_req = 0; bus.irq_req = 0; bus.prog_data = '0;

    step(1, 4'b0000, 0, 0, 0, 0, 0);
    step(1, S_Q4, 0, 0, 0, 0, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_ir_valid", bus.ir_valid, 0);

    // Straight-line fetch from the reset vector.
    run_cycle(0, 0, 0, 0, 0);
    check("t1_first_pc", bus.pc, 1);
    check("t1_first_flush", bus.ir_valid, 0);
    run_cycle(0, 0, 0, 0, 0);
    check("t1_first_live", bus.ir_valid, 1);
    check("t1_first_ir", bus.ir, rom[0]);
    for (int c = 0; c < 3; c++) run_cycle(0, 0, 0, 0, 0);
    check("t1_pc5", bus.pc, 5);

    // Branch at pc=5 to 0x123.
    run_cycle(1, 'h123, 0, 0, 0);
    check("t2_br_pc", bus.pc, 'h123);
    run_cycle(0, 0, 0, 0, 0);
    check("t2_nop", bus.ir_valid, 0);
    run_cycle(1, 7, 0, 0, 0);
    check("t2_target_ir", bus.ir, rom['h123]);

    // Skip issued at pc=8.
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    check("t3_skip_pc", bus.pc, 9);
    run_cycle(0, 0, 0, 0, 0);
    check("t3_skipped", bus.ir_valid, 0);
    run_cycle(1, 'h1F, 0, 0, 0);
    check("t3_after_skip_ir", bus.ir, rom[9]);

    // Interrupt at pc=0x20, then irq held alongside a branch.
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 0);
    check("t4_ack", bus.irq_ack, 1);
    check("t4_ret_pc", bus.ret_pc, 'h20);
    check("t4_vec", bus.pc, IRQ_PC);
    run_cycle(1, 'h40, 0, 1, 0);
    check("t4_ack_pulse", bus.irq_ack, 0);
    run_cycle(1, 'h40, 0, 1, 0);
    check("t4_br_wins", bus.pc, 'h40);
    run_cycle(0, 0, 0, 1, 0);
    check("t4_deferred", bus.irq_ack, 0);
    run_cycle(0, 0, 0, 1, 0);
    check("t4_late_ack", bus.irq_ack, 1);
    check("t4_late_ret", bus.ret_pc, 'h41);

    // PC wrap, hold across Q4, colliding strobes.
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(1, SPAN - 1, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    check("t5_wrap", bus.pc, 0);
    run_cycle(0, 0, 0, 0, 1);
    check("t5_hold_pc", bus.pc, 0);
    check("t5_hold_ir", bus.ir, rom[SPAN-1]);
    step(0, S_Q4, 0, 0, 0, 0, 0);
    step(0, 4'b1010, 0, 0, 0, 0, 0);
    check("t5_phase_err", bus.phase_err, 1);
    check("t5_err_pc", bus.pc, 1);

    // Reset between Q2 and Q3 of a branch cycle.
    step(0, S_Q1, 0, 1, 'h55, 0, 0);
    step(0, S_Q2, 0, 1, 'h55, 0, 0);
    step(1, S_Q3, 0, 1, 'h55, 0, 1);
    check("t6_pc", bus.pc, 0);
    check("t6_ack", bus.irq_ack, 0);
    check("t6_err", bus.phase_err, 0);
    step(0, S_Q4, 0, 1, 'h55, 0, 1);
    check("t6_resume_pc", bus.pc, 1);
    step(0, S_Q1, 0, 0, 0, 0, 0);
    check("t6_resume_ir", bus.ir, rom[0]);
    check("t6_resume_valid", bus.ir_valid, 1);
    step(0, S_Q2, 0, 0, 0, 0, 0);
    step(0, S_Q3, 0, 0, 0, 0, 0);

    // Randomized strobes, holds, gaps, resets and redirect requests.
    begin
      int ph;
      ph = 3;
      for (int i = 0; i < 4000; i++) begin
        logic [3:0]  q;
        bit          r, h, br, sk, irq;
        int unsigned tgt;
        r   = ($urandom_range(0, 299) == 0);
        h   = ($urandom_range(0, 9) == 0);
        br  = ($urandom_range(0, 5) == 0);
        sk  = ($urandom_range(0, 4) == 0);
        irq = ($urandom_range(0, 6) == 0);
        tgt = ($urandom_range(0, 3) == 0) ? SPAN - 1 - $urandom_range(0, 2)
                                          : $urandom_range(0, SPAN - 1);
        if ($urandom_range(0, 7) == 0) begin
          q = 4'b0000;
        end else if ($urandom_range(0, 799) == 0) begin
          q = 4'b0110;
        end else begin
          q  = S_Q1 >> ph;
          ph = (ph + 1) % 4;
        end
        step(r, q, h, br, tgt, sk, irq);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
